memoria_arbitrada: RTL and testbench



---
 rtl/memoria_arbitrada.sv | 124 ++++++++++++
 tb/tb_memoria_arbitrada.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memoria_arbitrada.sv
// Two-channel synchronous memory with round-robin req/ack arbitration, a registered
// completion pipeline of LATENCIA stages, and out-of-range address flagging.
module memoria_arbitrada #(
  parameter int BITS     = 16,
  parameter int TAMANHO  = 8,
  parameter int LATENCIA = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_a,
  input  logic            req_b,
  input  logic            write_a,
  input  logic            write_b,
  input  logic [BITS-1:0] endereco_a,
  input  logic [BITS-1:0] endereco_b,
  input  logic [BITS-1:0] dado_in_a,
  input  logic [BITS-1:0] dado_in_b,
  output logic            ack_a,
  output logic            ack_b,
  output logic            fim_a,
  output logic            fim_b,
  output logic            erro_a,
  output logic            erro_b,
  output logic [BITS-1:0] dado_out_a,
  output logic [BITS-1:0] dado_out_b
);

  localparam int DEPTH = 1 << TAMANHO;

  typedef struct packed {
    logic            valid;
    logic            ch;       // 0 = channel A, 1 = channel B
    logic            is_read;
    logic            erro;
    logic [BITS-1:0] data;
  } stage_t;

  logic [BITS-1:0]    r_mem [DEPTH];
  logic               r_ptr;   // 0 favours A, 1 favours B
  stage_t             r_pipe [LATENCIA];

  logic               w_xfer;
  logic               w_sel_b;
  logic               w_write;
  logic               w_in_range;
  logic [BITS-1:0]    w_addr;
  logic [BITS-1:0]    w_din;
  logic [TAMANHO-1:0] w_idx;
  stage_t             w_new;
  stage_t             w_last_next;

  // Handshake: a requester holds req/write/endereco/dado_in stable until it sees
  // ack high at a rising edge; that edge is the transfer. At most one ack per cycle.
  assign ack_a = reset_n & req_a & (~req_b | ~r_ptr);
  assign ack_b = reset_n & req_b & (~req_a |  r_ptr);

  assign w_xfer  = ack_a | ack_b;
  assign w_sel_b = ack_b;
  assign w_write = w_sel_b ? write_b    : write_a;
  assign w_addr  = w_sel_b ? endereco_b : endereco_a;
  assign w_din   = w_sel_b ? dado_in_b  : dado_in_a;
  assign w_idx   = TAMANHO'(w_addr);

  // Any set bit above the storage index makes the address illegal; no aliasing.
  generate
    if (TAMANHO < BITS) begin : g_range
      assign w_in_range = ~|w_addr[BITS-1:TAMANHO];
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  always_comb begin
    w_new         = '0;
    w_new.valid   = w_xfer;
    w_new.ch      = w_sel_b;
    w_new.is_read = ~w_write;
    w_new.erro    = ~w_in_range;
    if (~w_write && w_in_range)
      w_new.data = r_mem[w_idx];
  end

  // Value about to enter the last stage; dado_out is loaded from it so it lines up with fim.
  generate
    if (LATENCIA == 1) begin : g_lat1
      assign w_last_next = w_new;
    end else begin : g_latn
      assign w_last_next = r_pipe[LATENCIA-2];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (w_xfer && w_write && w_in_range)
      r_mem[w_idx] <= w_din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCIA; i++)
        r_pipe[i] <= '0;
      r_ptr      <= 1'b0;
      dado_out_a <= '0;
      dado_out_b <= '0;
    end else begin
      r_pipe[0] <= w_new;
      for (int i = 1; i < LATENCIA; i++)
        r_pipe[i] <= r_pipe[i-1];
      if (w_xfer)
        r_ptr <= ~w_sel_b;
      if (w_last_next.valid && w_last_next.is_read) begin
        if (w_last_next.ch)
          dado_out_b <= w_last_next.data;
        else
          dado_out_a <= w_last_next.data;
      end
    end
  end

  assign fim_a  = r_pipe[LATENCIA-1].valid & ~r_pipe[LATENCIA-1].ch;
  assign fim_b  = r_pipe[LATENCIA-1].valid &  r_pipe[LATENCIA-1].ch;
  assign erro_a = fim_a & r_pipe[LATENCIA-1].erro;
  assign erro_b = fim_b & r_pipe[LATENCIA-1].erro;

endmodule

// File: tb/tb_memoria_arbitrada.sv
// Directed bench for memoria_arbitrada: three instances at LATENCIA 1, 3 and 4,
// driven and sampled 1 ns after the rising edge.
module tb_memoria_arbitrada;

  logic        clock;
  logic        rst_n  [3];
  logic        req_a  [3];
  logic        req_b  [3];
  logic        wr_a   [3];
  logic        wr_b   [3];
  logic [15:0] end_a  [3];
  logic [15:0] end_b  [3];
  logic [15:0] din_a  [3];
  logic [15:0] din_b  [3];
  logic        ack_a  [3];
  logic        ack_b  [3];
  logic        fim_a  [3];
  logic        fim_b  [3];
  logic        erro_a [3];
  logic        erro_b [3];
  logic [15:0] dout_a [3];
  logic [15:0] dout_b [3];

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memoria_arbitrada #(
      .BITS(16), .TAMANHO(8),
      .LATENCIA((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clock(clock), .reset_n(rst_n[g]),
      .req_a(req_a[g]), .req_b(req_b[g]),
      .write_a(wr_a[g]), .write_b(wr_b[g]),
      .endereco_a(end_a[g]), .endereco_b(end_b[g]),
      .dado_in_a(din_a[g]), .dado_in_b(din_b[g]),
      .ack_a(ack_a[g]), .ack_b(ack_b[g]),
      .fim_a(fim_a[g]), .fim_b(fim_b[g]),
      .erro_a(erro_a[g]), .erro_b(erro_b[g]),
      .dado_out_a(dout_a[g]), .dado_out_b(dout_b[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic set_a(input int d, input logic rq, input logic wr,
                       input logic [15:0] ad, input logic [15:0] dt);
    req_a[d] = rq; wr_a[d] = wr; end_a[d] = ad; din_a[d] = dt;
  endtask

  task automatic set_b(input int d, input logic rq, input logic wr,
                       input logic [15:0] ad, input logic [15:0] dt);
    req_b[d] = rq; wr_b[d] = wr; end_b[d] = ad; din_b[d] = dt;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      set_a(d, 1'b0, 1'b0, 16'h0, 16'h0);
      set_b(d, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    req_a[0] = 1'b1;
    #1;
    chk("rst_ack_a", 32'(ack_a[0]), 32'd0);
    chk("rst_fim_a", 32'(fim_a[0]), 32'd0);
    chk("rst_dout_a", 32'(dout_a[0]), 32'h0);
    req_a[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // LATENCIA=1: write then read back on channel A
    set_a(0, 1'b1, 1'b1, 16'h0005, 16'h1234); #1;
    chk("t1_wr_ack", 32'(ack_a[0]), 32'd1);
    tick();
    chk("t1_wr_fim", 32'(fim_a[0]), 32'd1);
    chk("t1_wr_erro", 32'(erro_a[0]), 32'd0);
    chk("t1_wr_dout_kept", 32'(dout_a[0]), 32'h0);
    set_a(0, 1'b1, 1'b0, 16'h0005, 16'h0); #1;
    chk("t1_rd_ack", 32'(ack_a[0]), 32'd1);
    tick();
    chk("t1_rd_fim", 32'(fim_a[0]), 32'd1);
    chk("t1_rd_data", 32'(dout_a[0]), 32'h1234);
    chk("t1_rd_erro", 32'(erro_a[0]), 32'd0);
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("t1_fim_pulse_end", 32'(fim_a[0]), 32'd0);
    chk("t1_dout_held", 32'(dout_a[0]), 32'h1234);

    // out-of-range address, no aliasing onto word 0
    set_a(0, 1'b1, 1'b1, 16'h0000, 16'h5555); tick();
    set_a(0, 1'b1, 1'b1, 16'h0100, 16'hAAAA); tick();
    chk("t4_wr_oor_fim", 32'(fim_a[0]), 32'd1);
    chk("t4_wr_oor_erro", 32'(erro_a[0]), 32'd1);
    set_a(0, 1'b1, 1'b0, 16'h0100, 16'h0); tick();
    chk("t4_rd_oor_fim", 32'(fim_a[0]), 32'd1);
    chk("t4_rd_oor_erro", 32'(erro_a[0]), 32'd1);
    chk("t4_rd_oor_data", 32'(dout_a[0]), 32'h0);
    set_a(0, 1'b1, 1'b0, 16'h0000, 16'h0); tick();
    chk("t4_rd0_erro", 32'(erro_a[0]), 32'd0);
    chk("t4_rd0_data", 32'(dout_a[0]), 32'h5555);
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0); tick();

    // both channels reading from reset: grants alternate A, B, A, B
    rst_n[0] = 1'b0; #1; rst_n[0] = 1'b1;
    set_a(0, 1'b1, 1'b0, 16'h0000, 16'h0);
    set_b(0, 1'b1, 1'b0, 16'h0000, 16'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t2_ack_a", 32'(ack_a[0]), 32'((c % 2) == 0));
      chk("t2_ack_b", 32'(ack_b[0]), 32'((c % 2) == 1));
      tick();
      chk("t2_fim_a", 32'(fim_a[0]), 32'((c % 2) == 0));
      chk("t2_fim_b", 32'(fim_b[0]), 32'((c % 2) == 1));
      chk("t2_fim_excl", 32'(fim_a[0] & fim_b[0]), 32'd0);
      if ((c % 2) == 1) chk("t2_data_b", 32'(dout_b[0]), 32'h5555);
      else              chk("t2_data_a", 32'(dout_a[0]), 32'h5555);
    end
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_b(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("t2_idle_a", 32'(fim_a[0]), 32'd0);
    chk("t2_idle_b", 32'(fim_b[0]), 32'd0);

    // pointer favours B after an A grant; lone B is served every cycle
    set_a(0, 1'b1, 1'b0, 16'h0005, 16'h0); tick();
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_b(0, 1'b1, 1'b0, 16'h0005, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_ack_b", 32'(ack_b[0]), 32'd1);
      chk("t6_ack_a", 32'(ack_a[0]), 32'd0);
      tick();
      chk("t6_fim_b", 32'(fim_b[0]), 32'd1);
      chk("t6_data_b", 32'(dout_b[0]), 32'h1234);
    end
    set_b(0, 1'b0, 1'b0, 16'h0, 16'h0); tick();

    // LATENCIA=3: B write then read, back to back
    set_b(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF); tick();
    chk("t3_fim_k", 32'(fim_b[1]), 32'd0);
    set_b(1, 1'b1, 1'b0, 16'h0010, 16'h0); tick();
    chk("t3_fim_k1", 32'(fim_b[1]), 32'd0);
    set_b(1, 1'b0, 1'b0, 16'h0, 16'h0); tick();
    chk("t3_wr_fim", 32'(fim_b[1]), 32'd1);
    chk("t3_wr_dout_kept", 32'(dout_b[1]), 32'h0);
    tick();
    chk("t3_rd_fim", 32'(fim_b[1]), 32'd1);
    chk("t3_rd_data", 32'(dout_b[1]), 32'hBEEF);
    tick();
    chk("t3_fim_end", 32'(fim_b[1]), 32'd0);

    // LATENCIA=4: in-flight read dropped by reset, storage survives
    set_a(2, 1'b1, 1'b1, 16'h0003, 16'h0077); tick();
    set_a(2, 1'b1, 1'b0, 16'h0003, 16'h0); tick();
    set_a(2, 1'b0, 1'b0, 16'h0, 16'h0); tick(); tick();
    chk("t5_wr_fim", 32'(fim_a[2]), 32'd1);
    tick();
    chk("t5_rd_fim", 32'(fim_a[2]), 32'd1);
    chk("t5_rd_data", 32'(dout_a[2]), 32'h0077);
    tick();
    set_a(2, 1'b1, 1'b0, 16'h0003, 16'h0); tick();
    set_a(2, 1'b0, 1'b0, 16'h0, 16'h0); tick(); tick();
    rst_n[2] = 1'b0;
    req_a[2] = 1'b1;
    #1;
    chk("t5_rst_dout", 32'(dout_a[2]), 32'h0);
    chk("t5_rst_fim", 32'(fim_a[2]), 32'd0);
    chk("t5_rst_ack", 32'(ack_a[2]), 32'd0);
    req_a[2] = 1'b0;
    #2;
    rst_n[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t5_no_fim", 32'(fim_a[2]), 32'd0);
    end
    set_a(2, 1'b1, 1'b0, 16'h0003, 16'h0); tick();
    set_a(2, 1'b0, 1'b0, 16'h0, 16'h0); tick(); tick(); tick();
    chk("t5_post_fim", 32'(fim_a[2]), 32'd1);
    chk("t5_post_data", 32'(dout_a[2]), 32'h0077);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
